// File: rtl/aes_ctr_pkg.sv
// Shared constants and types for the AES-128 CTR word packer and CTR core wrapper.
package aes_ctr_pkg;
   localparam int WORD_W        = 32;
   localparam int BLOCK_W       = 128;
   localparam int CNT_W         = 64;
   localparam int WORDS_PER_BLK = BLOCK_W / WORD_W;
   localparam int KEEP_W        = WORD_W / 8;
   localparam int MASK_W        = BLOCK_W / 8;
   localparam int IDX_W         = $clog2(WORDS_PER_BLK);

   typedef enum logic {FILL, HOLD} packer_state_t;

   typedef logic [WORD_W-1:0]  word_t;
   typedef logic [KEEP_W-1:0]  keep_t;
   typedef logic [BLOCK_W-1:0] block_t;
   typedef logic [MASK_W-1:0]  mask_t;
   typedef logic [CNT_W-1:0]   ctr_t;
endpackage

// File: rtl/aes_ctr_word_packer_if.sv
// Word-in / block-out handshake bundle of the CTR packer; slave side is the packer.
interface aes_ctr_word_packer_if
   import aes_ctr_pkg::*;
   ();
   logic   in_valid;
   logic   in_ready;
   word_t  in_data;
   keep_t  in_keep;
   logic   in_last;
   logic   out_valid;
   logic   out_ready;
   block_t out_block;
   mask_t  out_mask;
   logic   out_last;
   ctr_t   out_ctr;
   logic   ctr_load;
   ctr_t   ctr_init;
   logic   ctr_wrap;

   modport master (
      output in_valid, in_data, in_keep, in_last, out_ready, ctr_load, ctr_init,
      input  in_ready, out_valid, out_block, out_mask, out_last, out_ctr, ctr_wrap
   );

   modport slave (
      input  in_valid, in_data, in_keep, in_last, out_ready, ctr_load, ctr_init,
      output in_ready, out_valid, out_block, out_mask, out_last, out_ctr, ctr_wrap
   );
endinterface

// File: rtl/aes_ctr_ctr_gen.sv
// Block counter for the CTR packer: load, increment per emitted block, sticky wrap flag.
module aes_ctr_ctr_gen
   import aes_ctr_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  ctr_t i_init,
   input  logic i_inc,
   output ctr_t o_ctr,
   output ctr_t o_ctr_next,
   output logic o_wrap
);
   ctr_t r_ctr;
   logic r_wrap;

   assign o_ctr      = r_ctr;
   assign o_ctr_next = r_ctr + ctr_t'(1);
   assign o_wrap     = r_wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctr  <= '0;
         r_wrap <= 1'b0;
      end else if (i_load) begin
         r_ctr  <= i_init;
         r_wrap <= 1'b0;
      end else if (i_inc) begin
         r_ctr <= o_ctr_next;
         if (&r_ctr)
            r_wrap <= 1'b1;
      end
   end
endmodule

// File: rtl/aes_ctr_word_packer.sv
// Packs 32-bit words into 128-bit CTR blocks tagged with counter, byte mask and last flag.
// Define AES_CTR_PACKER_BYTESWAP_EN to byte-reverse each input word and keep for little-endian buses.
module aes_ctr_word_packer
   import aes_ctr_pkg::*;
(
   input  logic clk,
   input  logic rst,
   aes_ctr_word_packer_if.slave bus
);
   packer_state_t    r_state;
   logic [IDX_W-1:0] r_idx;
   block_t           r_block;
   mask_t            r_mask;
   logic             r_last;
   logic             r_valid;
   ctr_t             r_out_ctr;

   word_t w_word;
   keep_t w_keep;
   logic  w_in_ready;
   logic  w_accept;
   logic  w_hs;
   logic  w_done;
   ctr_t  w_ctr;
   ctr_t  w_ctr_next;
   logic  w_wrap;

   // Byte lanes are realigned (optionally swapped) and bytes with keep=0 are zeroed.
   for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_byte
`ifdef AES_CTR_PACKER_BYTESWAP_EN
      localparam int SRC = KEEP_W - 1 - gi;
`else
      localparam int SRC = gi;
`endif
      assign w_keep[gi]          = bus.in_keep[SRC];
      assign w_word[gi*8 +: 8]   = bus.in_keep[SRC] ? bus.in_data[SRC*8 +: 8] : 8'h00;
   end

   assign w_in_ready = !bus.ctr_load && ((r_state == FILL) || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_hs       = r_valid && bus.out_ready && !bus.ctr_load;
   assign w_done     = bus.in_last || (r_idx == IDX_W'(WORDS_PER_BLK - 1));

   aes_ctr_ctr_gen u_ctr_gen (
      .clk        (clk),
      .rst        (rst),
      .i_load     (bus.ctr_load),
      .i_init     (bus.ctr_init),
      .i_inc      (w_hs),
      .o_ctr      (w_ctr),
      .o_ctr_next (w_ctr_next),
      .o_wrap     (w_wrap)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= FILL;
         r_idx     <= '0;
         r_block   <= '0;
         r_mask    <= '0;
         r_last    <= 1'b0;
         r_valid   <= 1'b0;
         r_out_ctr <= '0;
      end else if (bus.ctr_load) begin
         r_state <= FILL;
         r_idx   <= '0;
         r_block <= '0;
         r_mask  <= '0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_accept) begin
                  for (int k = 0; k < WORDS_PER_BLK; k++) begin
                     if (int'(r_idx) == k) begin
                        r_block[BLOCK_W-1-k*WORD_W -: WORD_W] <= w_word;
                        r_mask[MASK_W-1-k*KEEP_W -: KEEP_W]   <= w_keep;
                     end
                  end
                  if (w_done) begin
                     r_state   <= HOLD;
                     r_valid   <= 1'b1;
                     r_out_ctr <= w_ctr;
                     r_last    <= bus.in_last;
                     r_idx     <= '0;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end
            end
            HOLD: begin
               if (w_hs) begin
                  r_block <= '0;
                  r_mask  <= '0;
                  r_idx   <= '0;
                  r_last  <= 1'b0;
                  r_valid <= 1'b0;
                  r_state <= FILL;
                  // A word accepted alongside the handshake opens the next block in slot 0.
                  if (w_accept) begin
                     r_block[BLOCK_W-1 -: WORD_W] <= w_word;
                     r_mask[MASK_W-1 -: KEEP_W]   <= w_keep;
                     if (bus.in_last) begin
                        r_state   <= HOLD;
                        r_valid   <= 1'b1;
                        r_last    <= 1'b1;
                        r_out_ctr <= w_ctr_next;
                     end else begin
                        r_idx <= IDX_W'(1);
                     end
                  end
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_valid;
   assign bus.out_block = r_block;
   assign bus.out_mask  = r_mask;
   assign bus.out_last  = r_last;
   assign bus.out_ctr   = r_out_ctr;
   assign bus.ctr_wrap  = w_wrap;
endmodule

// File: tb/tb_aes_ctr_word_packer.sv
// Directed self-checking bench for aes_ctr_word_packer (streaming, partial, stall, wrap, load, swap).
module tb_aes_ctr_word_packer;
   import aes_ctr_pkg::*;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   aes_ctr_word_packer_if bus ();

   aes_ctr_word_packer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Bench drives pre-swapped data so expectations stay big-endian in either build.
   function automatic logic [31:0] sw(input logic [31:0] d);
`ifdef AES_CTR_PACKER_BYTESWAP_EN
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
      return d;
`endif
   endfunction

   function automatic logic [3:0] swk(input logic [3:0] k);
`ifdef AES_CTR_PACKER_BYTESWAP_EN
      return {k[0], k[1], k[2], k[3]};
`else
      return k;
`endif
   endfunction

   function automatic logic [31:0] wd(input logic [7:0] tag, input int i);
      return {tag, 8'(i), ~tag, 8'(i + 8'h40)};
   endfunction

   task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
      bit done = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = sw(d);
      bus.in_keep  = swk(k);
      bus.in_last  = l;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         done = bus.in_ready;
         @(posedge clk);
         #1;
      end
      if (!done) check("accept_timeout", 128'd0, 128'd1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      $display("word %h keep %b last %0d accepted", d, k, l);
   endtask

   task automatic load_ctr(input logic [63:0] v);
      bus.ctr_load = 1'b1;
      bus.ctr_init = v;
      @(negedge clk);
      check("load_in_ready", {127'd0, bus.in_ready}, 128'd0);
      @(posedge clk);
      #1;
      bus.ctr_load = 1'b0;
      $display("ctr_load %h", v);
   endtask

   task automatic handshake_idle();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("post_hs_valid", {127'd0, bus.out_valid}, 128'd0);
   endtask

   logic [127:0] exp_blk;
   logic [31:0]  exp_sw;

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_keep   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      bus.ctr_load  = 1'b0;
      bus.ctr_init  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      check("rst_valid", {127'd0, bus.out_valid}, 128'd0);
      check("rst_block", bus.out_block, 128'd0);
      check("rst_mask",  {112'd0, bus.out_mask}, 128'd0);
      check("rst_last",  {127'd0, bus.out_last}, 128'd0);
      check("rst_ctr",   {64'd0, bus.out_ctr}, 128'd0);
      check("rst_wrap",  {127'd0, bus.ctr_wrap}, 128'd0);
      check("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);

      // Two back-to-back full blocks
      bus.out_ready = 1'b1;
      load_ctr(64'h10);
      for (int i = 0; i < 8; i++) begin
         send_word({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, 4'hF, 1'b0);
         if (i == 3) begin
            check("b1_valid", {127'd0, bus.out_valid}, 128'd1);
            check("b1_block", bus.out_block, 128'h000102030405060708090A0B0C0D0E0F);
            check("b1_ctr",   {64'd0, bus.out_ctr}, 128'h10);
            check("b1_mask",  {112'd0, bus.out_mask}, 128'hFFFF);
            check("b1_last",  {127'd0, bus.out_last}, 128'd0);
            check("b1_in_ready", {127'd0, bus.in_ready}, 128'd1);
         end
         if (i == 4) check("b2_first_fill", {127'd0, bus.out_valid}, 128'd0);
         if (i == 7) begin
            check("b2_valid", {127'd0, bus.out_valid}, 128'd1);
            check("b2_block", bus.out_block, 128'h101112131415161718191A1B1C1D1E1F);
            check("b2_ctr",   {64'd0, bus.out_ctr}, 128'h11);
            check("b2_mask",  {112'd0, bus.out_mask}, 128'hFFFF);
         end
      end
      handshake_idle();

      // Partial final block: 3 words, last keeps two bytes
      send_word(32'hA0A1A2A3, 4'hF, 1'b0);
      send_word(32'hB0B1B2B3, 4'hF, 1'b0);
      send_word(32'hC0C1C2C3, 4'b1100, 1'b1);
      check("p_valid", {127'd0, bus.out_valid}, 128'd1);
      check("p_block", bus.out_block, 128'hA0A1A2A3_B0B1B2B3_C0C10000_00000000);
      check("p_mask",  {112'd0, bus.out_mask}, 128'hFFC0);
      check("p_last",  {127'd0, bus.out_last}, 128'd1);
      check("p_ctr",   {64'd0, bus.out_ctr}, 128'h12);
      handshake_idle();

      // Downstream stall for 5 cycles while a word waits
      bus.out_ready = 1'b0;
      exp_blk = '0;
      for (int i = 0; i < 4; i++) begin
         send_word(wd(8'hD5, i), 4'hF, 1'b0);
         exp_blk = {exp_blk[95:0], wd(8'hD5, i)};
      end
      bus.in_valid = 1'b1;
      bus.in_data  = sw(wd(8'hE7, 0));
      bus.in_keep  = swk(4'hF);
      bus.in_last  = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check("stall_in_ready", {127'd0, bus.in_ready}, 128'd0);
         check("stall_block", bus.out_block, exp_blk);
         check("stall_ctr", {64'd0, bus.out_ctr}, 128'h13);
         $display("stall cycle %0d", c);
      end
      bus.out_ready = 1'b1;
      #1;
      check("release_in_ready", {127'd0, bus.in_ready}, 128'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("release_fill", {127'd0, bus.out_valid}, 128'd0);
      exp_blk = {wd(8'hE7, 0), 96'd0};
      for (int i = 1; i < 4; i++) begin
         send_word(wd(8'hE7, i), 4'hF, 1'b0);
         exp_blk = {exp_blk[127:96] , exp_blk[95:0]};
      end
      exp_blk = {wd(8'hE7, 0), wd(8'hE7, 1), wd(8'hE7, 2), wd(8'hE7, 3)};
      check("stall_next_block", bus.out_block, exp_blk);
      check("stall_next_ctr", {64'd0, bus.out_ctr}, 128'h14);
      handshake_idle();

      // Counter wrap
      load_ctr(64'hFFFF_FFFF_FFFF_FFFF);
      for (int i = 0; i < 4; i++) send_word(wd(8'h3C, i), 4'hF, 1'b0);
      check("wrap_ctr0", {64'd0, bus.out_ctr}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
      check("wrap_pre", {127'd0, bus.ctr_wrap}, 128'd0);
      send_word(wd(8'h5A, 0), 4'hF, 1'b0);
      check("wrap_set", {127'd0, bus.ctr_wrap}, 128'd1);
      for (int i = 1; i < 4; i++) send_word(wd(8'h5A, i), 4'hF, 1'b0);
      check("wrap_ctr1", {64'd0, bus.out_ctr}, 128'd0);
      check("wrap_block", bus.out_block,
            {wd(8'h5A, 0), wd(8'h5A, 1), wd(8'h5A, 2), wd(8'h5A, 3)});
      handshake_idle();
      check("wrap_sticky", {127'd0, bus.ctr_wrap}, 128'd1);

      // Counter load mid-block discards the partial block
      send_word(wd(8'h99, 0), 4'hF, 1'b0);
      send_word(wd(8'h99, 1), 4'hF, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = sw(wd(8'h99, 2));
      bus.in_keep  = swk(4'hF);
      load_ctr(64'h200);
      bus.in_valid = 1'b0;
      check("load_valid", {127'd0, bus.out_valid}, 128'd0);
      check("load_wrap_clr", {127'd0, bus.ctr_wrap}, 128'd0);
      for (int i = 0; i < 3; i++) send_word(wd(8'h66, i), 4'hF, 1'b0);
      check("load_no_early", {127'd0, bus.out_valid}, 128'd0);
      send_word(wd(8'h66, 3), 4'hF, 1'b0);
      check("load_blk_valid", {127'd0, bus.out_valid}, 128'd1);
      check("load_block", bus.out_block,
            {wd(8'h66, 0), wd(8'h66, 1), wd(8'h66, 2), wd(8'h66, 3)});
      check("load_ctr", {64'd0, bus.out_ctr}, 128'h200);
      handshake_idle();

      // Raw single-word last block shows the lane order of this build
`ifdef AES_CTR_PACKER_BYTESWAP_EN
      exp_sw = 32'h44332211;
`else
      exp_sw = 32'h11223344;
`endif
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h11223344;
      bus.in_keep  = 4'hF;
      bus.in_last  = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      $display("raw word 11223344 last");
      check("swap_block", bus.out_block, {exp_sw, 96'd0});
      check("swap_mask", {112'd0, bus.out_mask}, 128'hF000);
      check("swap_last", {127'd0, bus.out_last}, 128'd1);
      check("swap_ctr", {64'd0, bus.out_ctr}, 128'h201);
      handshake_idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
